// File: rtl/food_placer_if.sv
// Signal bundle between the game controller / occupancy store (master side)
// and the food placer (slave side).
interface food_placer_if #(
    parameter int X_WIDTH = 7,
    parameter int Y_WIDTH = 6
);
    logic [X_WIDTH-1:0] frame_x_inside_grid;
    logic [Y_WIDTH-1:0] frame_y_inside_grid;
    logic [X_WIDTH-1:0] number_x_grid;
    logic [Y_WIDTH-1:0] number_y_grid;
    logic               place_req;
    logic               query_valid;
    logic [X_WIDTH-1:0] query_x;
    logic [Y_WIDTH-1:0] query_y;
    logic               occ_hit;
    logic [X_WIDTH-1:0] food_x;
    logic [Y_WIDTH-1:0] food_y;
    logic               food_valid;
    logic               place_fail;
    logic               busy;

    modport master (
        output frame_x_inside_grid, frame_y_inside_grid, number_x_grid, number_y_grid,
        output place_req, occ_hit,
        input  query_valid, query_x, query_y, food_x, food_y, food_valid, place_fail, busy
    );

    modport slave (
        input  frame_x_inside_grid, frame_y_inside_grid, number_x_grid, number_y_grid,
        input  place_req, occ_hit,
        output query_valid, query_x, query_y, food_x, food_y, food_valid, place_fail, busy
    );
endinterface

// File: rtl/food_placer.sv
// Food-coordinate generator: LFSR draw inside the playable frame, then a
// linear scan through occupied cells using a one-cycle occupancy query.
module food_placer #(
    parameter int          X_WIDTH   = 7,
    parameter int          Y_WIDTH   = 6,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_DRAWS = 8,
    parameter int          RESET_X   = 20,
    parameter int          RESET_Y   = 20
) (
    input  logic         clk,
    input  logic         reset,
    food_placer_if.slave bus
);
    localparam int                 C_WIDTH    = X_WIDTH + Y_WIDTH;
    localparam int                 D_WIDTH    = $clog2(MAX_DRAWS + 1);
    localparam logic [15:0]        SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [D_WIDTH-1:0] DRAW_LIMIT = D_WIDTH'(MAX_DRAWS);
    localparam logic [X_WIDTH-1:0] FOOD_X_RST = X_WIDTH'(RESET_X);
    localparam logic [Y_WIDTH-1:0] FOOD_Y_RST = Y_WIDTH'(RESET_Y);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_QUERY = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [15:0]        lfsr_r;
    logic [X_WIDTH-1:0] x_min_r, x_max_r, cand_x_r, cand_x_s, food_x_r, food_x_s;
    logic [Y_WIDTH-1:0] y_min_r, y_max_r, cand_y_r, cand_y_s, food_y_r, food_y_s;
    logic [C_WIDTH-1:0] cells_r, scan_r, scan_inc_s, cells_s;
    logic [D_WIDTH-1:0] draw_r, draw_inc_s;
    logic               query_valid_r, food_valid_r, place_fail_r, busy_r;
    logic               query_valid_s, food_valid_s, place_fail_s, busy_s;

    logic [X_WIDTH:0]   x_diff_s, x_span_s;
    logic [Y_WIDTH:0]   y_diff_s, y_span_s;
    logic               degenerate_s, in_range_s, draw_done_s, scan_done_s;
    logic [X_WIDTH-1:0] lfsr_x_s;
    logic [Y_WIDTH-1:0] lfsr_y_s;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Frame limits from the live inputs; the top diff bit flags a wrapped subtraction.
    assign x_diff_s = {1'b0, bus.number_x_grid} - {1'b0, bus.frame_x_inside_grid}
                      - {{X_WIDTH{1'b0}}, 1'b1};
    assign y_diff_s = {1'b0, bus.number_y_grid} - {1'b0, bus.frame_y_inside_grid}
                      - {{Y_WIDTH{1'b0}}, 1'b1};
    assign x_span_s = {1'b0, x_diff_s[X_WIDTH-1:0]} - {1'b0, bus.frame_x_inside_grid}
                      + {{X_WIDTH{1'b0}}, 1'b1};
    assign y_span_s = {1'b0, y_diff_s[Y_WIDTH-1:0]} - {1'b0, bus.frame_y_inside_grid}
                      + {{Y_WIDTH{1'b0}}, 1'b1};
    assign cells_s  = {{(Y_WIDTH-1){1'b0}}, x_span_s} * {{(X_WIDTH-1){1'b0}}, y_span_s};
    assign degenerate_s = x_diff_s[X_WIDTH] | y_diff_s[Y_WIDTH]
                        | (x_diff_s[X_WIDTH-1:0] < bus.frame_x_inside_grid)
                        | (y_diff_s[Y_WIDTH-1:0] < bus.frame_y_inside_grid);

    assign lfsr_x_s    = lfsr_r[X_WIDTH-1:0];
    assign lfsr_y_s    = lfsr_r[C_WIDTH-1:X_WIDTH];
    assign in_range_s  = (lfsr_x_s >= x_min_r) && (lfsr_x_s <= x_max_r)
                      && (lfsr_y_s >= y_min_r) && (lfsr_y_s <= y_max_r);
    assign draw_inc_s  = draw_r + D_WIDTH'(1'b1);
    assign draw_done_s = (draw_inc_s == DRAW_LIMIT);
    assign scan_inc_s  = scan_r + C_WIDTH'(1'b1);
    assign scan_done_s = (scan_inc_s == cells_r);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.place_req && !degenerate_s) state_s = ST_DRAW;
                else                                state_s = ST_IDLE;
            end
            ST_DRAW: begin
                if (in_range_s || draw_done_s) state_s = ST_QUERY;
                else                           state_s = ST_DRAW;
            end
            ST_QUERY: state_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.occ_hit && !scan_done_s) state_s = ST_QUERY;
                else                             state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output and candidate next values, all captured by registers below.
    always_comb begin
        cand_x_s     = cand_x_r;
        cand_y_s     = cand_y_r;
        food_x_s     = food_x_r;
        food_y_s     = food_y_r;
        food_valid_s = 1'b0;
        place_fail_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.place_req && degenerate_s) place_fail_s = 1'b1;
                else                               place_fail_s = 1'b0;
            end
            ST_DRAW: begin
                if (in_range_s) begin
                    cand_x_s = lfsr_x_s;
                    cand_y_s = lfsr_y_s;
                end else if (draw_done_s) begin
                    cand_x_s = x_min_r;
                    cand_y_s = y_min_r;
                end else begin
                    cand_x_s = cand_x_r;
                    cand_y_s = cand_y_r;
                end
            end
            ST_WAIT: begin
                if (!bus.occ_hit) begin
                    food_x_s     = cand_x_r;
                    food_y_s     = cand_y_r;
                    food_valid_s = 1'b1;
                end else if (scan_done_s) begin
                    place_fail_s = 1'b1;
                end else if (cand_x_r == x_max_r) begin
                    cand_x_s = x_min_r;
                    if (cand_y_r == y_max_r) cand_y_s = y_min_r;
                    else                     cand_y_s = cand_y_r + Y_WIDTH'(1'b1);
                end else begin
                    cand_x_s = cand_x_r + X_WIDTH'(1'b1);
                end
            end
            default: begin
                food_valid_s = 1'b0;
            end
        endcase
        query_valid_s = (state_s == ST_QUERY);
        busy_s        = (state_s != ST_IDLE);
    end

    // Free-running LFSR, bounds latch and the draw/scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r  <= SEED_EFF;
            x_min_r <= {X_WIDTH{1'b0}};
            x_max_r <= {X_WIDTH{1'b0}};
            y_min_r <= {Y_WIDTH{1'b0}};
            y_max_r <= {Y_WIDTH{1'b0}};
            cells_r <= {C_WIDTH{1'b0}};
            scan_r  <= {C_WIDTH{1'b0}};
            draw_r  <= {D_WIDTH{1'b0}};
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
            case (state_r)
                ST_IDLE: begin
                    if (bus.place_req) begin
                        x_min_r <= bus.frame_x_inside_grid;
                        x_max_r <= x_diff_s[X_WIDTH-1:0];
                        y_min_r <= bus.frame_y_inside_grid;
                        y_max_r <= y_diff_s[Y_WIDTH-1:0];
                        cells_r <= cells_s;
                        scan_r  <= {C_WIDTH{1'b0}};
                        draw_r  <= {D_WIDTH{1'b0}};
                    end
                end
                ST_DRAW: begin
                    if (!in_range_s) draw_r <= draw_inc_s;
                end
                ST_WAIT: begin
                    if (bus.occ_hit) scan_r <= scan_inc_s;
                end
                default: begin
                    draw_r <= draw_r;
                end
            endcase
        end
    end

    // Registered outputs; the candidate register doubles as the query address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_x_r      <= {X_WIDTH{1'b0}};
            cand_y_r      <= {Y_WIDTH{1'b0}};
            food_x_r      <= FOOD_X_RST;
            food_y_r      <= FOOD_Y_RST;
            food_valid_r  <= 1'b0;
            place_fail_r  <= 1'b0;
            query_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            cand_x_r      <= cand_x_s;
            cand_y_r      <= cand_y_s;
            food_x_r      <= food_x_s;
            food_y_r      <= food_y_s;
            food_valid_r  <= food_valid_s;
            place_fail_r  <= place_fail_s;
            query_valid_r <= query_valid_s;
            busy_r        <= busy_s;
        end
    end

    assign bus.query_valid = query_valid_r;
    assign bus.query_x     = cand_x_r;
    assign bus.query_y     = cand_y_r;
    assign bus.food_x      = food_x_r;
    assign bus.food_y      = food_y_r;
    assign bus.food_valid  = food_valid_r;
    assign bus.place_fail  = place_fail_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_food_placer.sv
// Table-driven bench for food_placer with a behavioural placement model and
// a scoreboard of expected placement results.
module tb_food_placer;
    localparam int          XW   = 7;
    localparam int          YW   = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset;

    food_placer_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    food_placer #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .SEED(SEED),
        .MAX_DRAWS(8), .RESET_X(20), .RESET_Y(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    nx, fx, ny, fy, nocc, kind;
    } vec_t;

    typedef struct {
        bit fail;
        int x, y, lat, nq, qx, qy;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] lfsr_m;
    int          nq_seen, cur_nocc, q_x, q_y;
    int          last_fx = 20;
    int          last_fy = 20;

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: model LFSR follows the DUT, occupancy answers each query.
    task automatic tick();
        bit r;
        @(posedge clk);
        r = reset;
        #1;
        if (r) lfsr_m = SEED;
        else   lfsr_m = step(lfsr_m);
        if (bus.query_valid) begin
            nq_seen++;
            if (nq_seen == 1) begin
                q_x = int'(bus.query_x);
                q_y = int'(bus.query_y);
            end
            bus.occ_hit = (nq_seen <= cur_nocc);
        end
    endtask

    function automatic void predict(input logic [15:0] l0, input int nx, fx, ny, fy, nocc,
                                    output bit fail, output int ex, ey, lat, nq, qx, qy);
        int xmax, ymax, cells, draws, cx, cy, h;
        logic [15:0] l;
        bit inr;
        xmax = nx - fx - 1;
        ymax = ny - fy - 1;
        fail = 1'b0; ex = last_fx; ey = last_fy; lat = 1; nq = 0; qx = 0; qy = 0;
        if (xmax < 0 || ymax < 0 || xmax < fx || ymax < fy) begin
            fail = 1'b1;
            return;
        end
        l = l0; draws = 0;
        do begin
            l = step(l);
            draws++;
            cx = int'(l[6:0]);
            cy = int'(l[12:7]);
            inr = (cx >= fx && cx <= xmax && cy >= fy && cy <= ymax);
        end while (!inr && draws < 8);
        if (!inr) begin
            cx = fx;
            cy = fy;
        end
        qx = cx; qy = cy;
        cells = (xmax - fx + 1) * (ymax - fy + 1);
        h = 0; nq = 1;
        while (h < nocc) begin
            h++;
            if (h == cells) begin
                fail = 1'b1;
                break;
            end
            if (cx == xmax) begin
                cx = fx;
                cy = (cy == ymax) ? fy : cy + 1;
            end else begin
                cx = cx + 1;
            end
            nq++;
        end
        lat = 1 + draws + 2 * nq;
        if (!fail) begin
            ex = cx;
            ey = cy;
        end
    endfunction

    task automatic run_req(input string name, input int nx, fx, ny, fy, nocc, kind,
                           input bit disturb);
        exp_t e, g;
        bit   f, seen;
        int   ex, ey, lat, nq, qx, qy, k;
        bus.number_x_grid       = XW'(nx);
        bus.frame_x_inside_grid = XW'(fx);
        bus.number_y_grid       = YW'(ny);
        bus.frame_y_inside_grid = YW'(fy);
        predict(lfsr_m, nx, fx, ny, fy, nocc, f, ex, ey, lat, nq, qx, qy);
        e.fail = f; e.x = ex; e.y = ey; e.lat = lat; e.nq = nq; e.qx = qx; e.qy = qy;
        sb.push_back(e);
        cur_nocc = nocc; nq_seen = 0; bus.occ_hit = 1'b0;
        bus.place_req = 1'b1;
        tick();
        bus.place_req = 1'b0;
        k = 1; seen = 1'b0;
        while (k <= 200) begin
            if (bus.food_valid || bus.place_fail) begin
                seen = 1'b1;
                break;
            end
            if (disturb && k == 1) begin
                bus.number_x_grid = XW'(4);
                bus.place_req     = 1'b1;
            end
            if (disturb && k == 2) bus.place_req = 1'b0;
            tick();
            k++;
        end
        g = sb.pop_front();
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s/timeout: no result within 200 cycles", name);
            return;
        end
        check({name, "/kind"}, int'(bus.place_fail), kind);
        check({name, "/exclusive"}, int'(bus.place_fail & bus.food_valid), 0);
        check({name, "/latency"}, k, g.lat);
        check({name, "/food_x"}, int'(bus.food_x), g.x);
        check({name, "/food_y"}, int'(bus.food_y), g.y);
        check({name, "/busy"}, int'(bus.busy), 0);
        check({name, "/queries"}, nq_seen, g.nq);
        if (g.nq > 0) begin
            check({name, "/query0_x"}, q_x, g.qx);
            check({name, "/query0_y"}, q_y, g.qy);
        end
        if (!g.fail) begin
            last_fx = g.x;
            last_fy = g.y;
        end
    endtask

    initial begin
        bit found, stray;
        int k, px, py, d1, d2, d3, d4;
        bit pf;

        vecs[0]  = '{"free",          80, 2, 60, 2, 0,  0};
        vecs[1]  = '{"free_occ2",     80, 2, 60, 2, 2,  0};
        vecs[2]  = '{"narrow_occ3",    6, 2, 60, 2, 3,  0};
        vecs[3]  = '{"quad_occ3",      6, 2,  6, 2, 3,  0};
        vecs[4]  = '{"quad_full",      6, 2,  6, 2, 4,  1};
        vecs[5]  = '{"single_full",    5, 2,  5, 2, 99, 1};
        vecs[6]  = '{"degen_x",        4, 2, 60, 2, 0,  1};
        vecs[7]  = '{"degen_wrap_x",   1, 2, 60, 2, 0,  1};
        vecs[8]  = '{"degen_y",       80, 2,  4, 2, 0,  1};
        vecs[9]  = '{"single_free",    5, 2,  5, 2, 0,  0};
        vecs[10] = '{"degen_zero",     0, 0, 60, 2, 0,  1};
        vecs[11] = '{"full_grid",    127, 0, 63, 0, 1,  0};

        reset = 1'b1;
        bus.place_req = 1'b0;
        bus.occ_hit   = 1'b0;
        bus.number_x_grid = XW'(80);
        bus.frame_x_inside_grid = XW'(2);
        bus.number_y_grid = YW'(60);
        bus.frame_y_inside_grid = YW'(2);
        lfsr_m = SEED; cur_nocc = 0; nq_seen = 0; q_x = 0; q_y = 0;
        tick();
        tick();
        reset = 1'b0;
        check("reset/food_x", int'(bus.food_x), 20);
        check("reset/food_y", int'(bus.food_y), 20);
        check("reset/busy", int'(bus.busy), 0);
        check("reset/food_valid", int'(bus.food_valid), 0);
        check("reset/place_fail", int'(bus.place_fail), 0);
        check("reset/query_valid", int'(bus.query_valid), 0);
        check("reset/query_x", int'(bus.query_x), 0);
        check("reset/query_y", int'(bus.query_y), 0);
        tick();

        for (int i = 0; i < 12; i++)
            run_req(vecs[i].name, vecs[i].nx, vecs[i].fx, vecs[i].ny, vecs[i].fy,
                    vecs[i].nocc, vecs[i].kind, 1'b0);

        // place_req and bound changes while busy must be ignored
        run_req("busy_ignore", 80, 2, 60, 2, 2, 0, 1'b1);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.food_valid || bus.place_fail || bus.busy) stray = 1'b1;
        end
        check("busy_ignore/no_extra_op", int'(stray), 0);

        // wait for a first draw landing in x 74..77 so the occupied run crosses x_max
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            predict(lfsr_m, 80, 2, 60, 2, 0, pf, d1, d2, d3, d4, px, py);
            if (px >= 74 && px <= 77) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wrap77/search: no suitable draw within 3000 cycles");
        end else begin
            run_req("wrap77", 80, 2, 60, 2, 4, 0, 1'b0);
            check("wrap77/x_wrapped", int'(bus.food_x), px - 72);
            check("wrap77/y_stepped", int'(bus.food_y), (py == 57) ? 2 : py + 1);
        end

        for (int i = 0; i < 1000; i++) begin
            run_req("free_run", 80, 2, 60, 2, 0, 0, 1'b0);
            check("free_run/x_range", int'(bus.food_x >= 7'd2 && bus.food_x <= 7'd77), 1);
            check("free_run/y_range", int'(bus.food_y >= 6'd2 && bus.food_y <= 6'd57), 1);
        end

        // reset while waiting for an occupancy answer
        cur_nocc = 10; nq_seen = 0;
        bus.place_req = 1'b1;
        tick();
        bus.place_req = 1'b0;
        k = 0;
        while (nq_seen == 0 && k < 50) begin
            tick();
            k++;
        end
        check("rst_wait/query_seen", int'(nq_seen > 0), 1);
        tick();
        reset = 1'b1;
        lfsr_m = SEED;
        #1;
        check("rst_wait/food_x", int'(bus.food_x), 20);
        check("rst_wait/food_y", int'(bus.food_y), 20);
        check("rst_wait/busy", int'(bus.busy), 0);
        check("rst_wait/query_valid", int'(bus.query_valid), 0);
        check("rst_wait/query_x", int'(bus.query_x), 0);
        tick();
        tick();
        reset = 1'b0;
        last_fx = 20;
        last_fy = 20;
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.food_valid || bus.place_fail || bus.query_valid || bus.busy) stray = 1'b1;
        end
        check("rst_wait/no_pulse", int'(stray), 0);
        run_req("after_reset", 80, 2, 60, 2, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
